psram_arbiter: RTL and testbench



---
 rtl/psram_arb_pkg.sv | 27 ++
 rtl/psram_arbiter_if.sv | 34 +++
 rtl/psram_arb_pick.sv | 31 +++
 rtl/psram_arbiter.sv | 147 ++++++++++++++
 tb/tb_psram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the PSRAM port arbiter.
// Build option PSRAM_ARB_RR_EN selects round-robin instead of fixed priority.
package psram_arb_pkg;

  localparam int NPORT    = 3;
  localparam int PORT_SD  = 0;
  localparam int PORT_PPU = 1;
  localparam int PORT_CPU = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_ACK
  } arb_state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NPORT-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NPORT; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/psram_arbiter_if.sv
// Requester and controller signals of one PSRAM arbiter instance.
// The arbiter takes the slave side; requesters plus controller form the master side.
interface psram_arbiter_if #(
  parameter int ADRS_W = 20,
  parameter int DATA_W = 16
);
  logic              req0, req1, req2;
  logic              we0, we1, we2;
  logic [ADRS_W-1:0] adrs0, adrs1, adrs2;
  logic [DATA_W-1:0] wdata0, wdata1, wdata2;
  logic              ack0, ack1, ack2;
  logic [DATA_W-1:0] rdata;
  logic              psram_read, psram_write;
  logic [ADRS_W-1:0] psram_adrs;
  logic [DATA_W-1:0] psram_din;
  logic [DATA_W-1:0] psram_dout;
  logic              psram_busy;

  modport master (
    output req0, req1, req2, we0, we1, we2,
    output adrs0, adrs1, adrs2, wdata0, wdata1, wdata2,
    output psram_dout, psram_busy,
    input  ack0, ack1, ack2, rdata,
    input  psram_read, psram_write, psram_adrs, psram_din
  );

  modport slave (
    input  req0, req1, req2, we0, we1, we2,
    input  adrs0, adrs1, adrs2, wdata0, wdata1, wdata2,
    input  psram_dout, psram_busy,
    output ack0, ack1, ack2, rdata,
    output psram_read, psram_write, psram_adrs, psram_din
  );
endinterface

// File: rtl/psram_arb_pick.sv
// Combinational winner selection; one-hot grant plus valid.
// With PSRAM_ARB_RR_EN the search starts one past the last-granted port.
module psram_arb_pick
  import psram_arb_pkg::*;
(
  input  logic [NPORT-1:0] req,
`ifdef PSRAM_ARB_RR_EN
  input  logic [1:0]       ptr,
`endif
  output logic [NPORT-1:0] grant,
  output logic             valid
);

  always_comb begin
    grant = '0;
`ifdef PSRAM_ARB_RR_EN
    for (int k = 1; k <= NPORT; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NPORT;
      if (grant == '0 && req[idx]) grant[idx] = 1'b1;
    end
`else
    // Scanning downwards lets the lowest index overwrite, so port0 wins ties.
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (req[i]) grant = NPORT'(1) << i;
    end
`endif
    valid = |req;
  end

endmodule

// File: rtl/psram_arbiter.sv
// Shares one PsramController port between SD loader, PPU and CPU requesters.
// Build option PSRAM_ARB_RR_EN enables round-robin arbitration.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int ADRS_W    = 20,
  parameter int DATA_W    = 16,
  parameter int BUSY_WAIT = 3
)(
  input logic           m_clock,
  input logic           p_reset,
  psram_arbiter_if.slave bus
);

  arb_state_t        state;
  logic [1:0]        busy_cnt;
  logic [NPORT-1:0]  gnt_oh;
  logic              gnt_we;
  logic [NPORT-1:0]  ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic              read_q, write_q;
  logic [ADRS_W-1:0] adrs_q;
  logic [DATA_W-1:0] din_q;

  logic [NPORT-1:0]  req_vec;
  logic [NPORT-1:0]  grant;
  logic              grant_valid;
  logic              we_sel;
  logic [ADRS_W-1:0] adrs_sel;
  logic [DATA_W-1:0] wdata_sel;

  assign req_vec[PORT_SD]  = bus.req0;
  assign req_vec[PORT_PPU] = bus.req1;
  assign req_vec[PORT_CPU] = bus.req2;

`ifdef PSRAM_ARB_RR_EN
  logic [1:0] rr_ptr;

  psram_arb_pick u_pick (
    .req   (req_vec),
    .ptr   (rr_ptr),
    .grant (grant),
    .valid (grant_valid)
  );
`else
  psram_arb_pick u_pick (
    .req   (req_vec),
    .grant (grant),
    .valid (grant_valid)
  );
`endif

  always_comb begin
    we_sel    = 1'b0;
    adrs_sel  = '0;
    wdata_sel = '0;
    if (grant[PORT_SD]) begin
      we_sel    = bus.we0;
      adrs_sel  = bus.adrs0;
      wdata_sel = bus.wdata0;
    end else if (grant[PORT_PPU]) begin
      we_sel    = bus.we1;
      adrs_sel  = bus.adrs1;
      wdata_sel = bus.wdata1;
    end else if (grant[PORT_CPU]) begin
      we_sel    = bus.we2;
      adrs_sel  = bus.adrs2;
      wdata_sel = bus.wdata2;
    end
  end

  // Command pulses are set on the IDLE->ISSUE transition so they coincide with ISSUE.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state    <= ST_IDLE;
      busy_cnt <= '0;
      gnt_oh   <= '0;
      gnt_we   <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      adrs_q   <= '0;
      din_q    <= '0;
`ifdef PSRAM_ARB_RR_EN
      rr_ptr   <= 2'd0;
`endif
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      ack_q   <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_valid && !bus.psram_busy) begin
            gnt_oh  <= grant;
            gnt_we  <= we_sel;
            adrs_q  <= adrs_sel;
            din_q   <= wdata_sel;
            read_q  <= !we_sel;
            write_q <= we_sel;
`ifdef PSRAM_ARB_RR_EN
            rr_ptr  <= onehot_to_idx(grant);
`endif
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          busy_cnt <= '0;
          state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // A fast controller may finish before busy is ever seen; give up after BUSY_WAIT cycles.
          if (bus.psram_busy) begin
            state <= ST_WAIT_DONE;
          end else if (busy_cnt == 2'(BUSY_WAIT - 1)) begin
            state <= ST_WAIT_DONE;
          end else begin
            busy_cnt <= busy_cnt + 2'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.psram_busy) begin
            if (!gnt_we) rdata_q <= bus.psram_dout;
            ack_q <= gnt_oh;
            state <= ST_ACK;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack0        = ack_q[PORT_SD];
  assign bus.ack1        = ack_q[PORT_PPU];
  assign bus.ack2        = ack_q[PORT_CPU];
  assign bus.rdata       = rdata_q;
  assign bus.psram_read  = read_q;
  assign bus.psram_write = write_q;
  assign bus.psram_adrs  = adrs_q;
  assign bus.psram_din   = din_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: behavioural PSRAM controller plus
// a service-order/memory reference model; honours PSRAM_ARB_RR_EN.
module tb_psram_arbiter;
  import psram_arb_pkg::*;

  localparam int ADRS_W = 20;
  localparam int DATA_W = 16;

  logic m_clock = 1'b0;
  logic p_reset;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 m_clock = ~m_clock;
  always @(posedge m_clock) cycle <= cycle + 1;

  psram_arbiter_if #(.ADRS_W(ADRS_W), .DATA_W(DATA_W)) bus ();

  psram_arbiter #(.ADRS_W(ADRS_W), .DATA_W(DATA_W), .BUSY_WAIT(3)) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .bus     (bus.slave)
  );

  // Behavioural controller: busy rises mode_rise cycles after the pulse and lasts mode_len cycles.
  logic              ctrl_busy = 1'b0;
  logic              busy_hold = 1'b0;
  logic [DATA_W-1:0] ctrl_dout = '0;
  int                mode_rise = 0;
  int                mode_len  = 1;
  bit                mode_never = 1'b0;
  logic [DATA_W-1:0] ctrl_mem [logic [ADRS_W-1:0]];

  assign bus.psram_busy = ctrl_busy | busy_hold;
  assign bus.psram_dout = ctrl_dout;

  function automatic logic [DATA_W-1:0] dflt(input logic [ADRS_W-1:0] a);
    return a[15:0] ^ 16'h5A5A ^ {12'h000, a[19:16]};
  endfunction

  initial begin
    logic [ADRS_W-1:0] a;
    logic [DATA_W-1:0] rd;
    forever begin
      @(negedge m_clock);
      if (!p_reset && (bus.psram_read || bus.psram_write)) begin
        a = bus.psram_adrs;
        if (bus.psram_write) ctrl_mem[a] = bus.psram_din;
        rd = ctrl_mem.exists(a) ? ctrl_mem[a] : dflt(a);
        if (mode_never) begin
          ctrl_dout = rd;
        end else begin
          @(posedge m_clock);
          repeat (mode_rise) @(posedge m_clock);
          #1 ctrl_busy = 1'b1;
          repeat (mode_len) @(posedge m_clock);
          #1 ctrl_busy = 1'b0;
          ctrl_dout = rd;
        end
      end
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [logic [ADRS_W-1:0]];
  logic [DATA_W-1:0] last_rd = '0;
  int                ptr_m = 0;

  bit                p_we    [NPORT];
  logic [ADRS_W-1:0] p_adrs  [NPORT];
  logic [DATA_W-1:0] p_wdata [NPORT];

  function automatic int pick_next(input bit [2:0] rem);
`ifdef PSRAM_ARB_RR_EN
    for (int k = 1; k <= NPORT; k++) begin
      int idx;
      idx = (ptr_m + k) % NPORT;
      if (rem[idx]) return idx;
    end
`else
    for (int i = 0; i < NPORT; i++) begin
      if (rem[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_port(input int p, input bit req);
    case (p)
      0: begin bus.we0 = p_we[0]; bus.adrs0 = p_adrs[0]; bus.wdata0 = p_wdata[0]; bus.req0 = req; end
      1: begin bus.we1 = p_we[1]; bus.adrs1 = p_adrs[1]; bus.wdata1 = p_wdata[1]; bus.req1 = req; end
      default: begin bus.we2 = p_we[2]; bus.adrs2 = p_adrs[2]; bus.wdata2 = p_wdata[2]; bus.req2 = req; end
    endcase
  endtask

  task automatic preload(input logic [ADRS_W-1:0] a, input logic [DATA_W-1:0] d);
    ctrl_mem[a] = d;
    ref_mem[a]  = d;
  endtask

  // Raises the requests in mask, serves them to completion and compares against the model.
  task automatic apply_stimulus(input bit [2:0] mask, input string tag);
    int exp_order[$];
    int cmd_cyc[$], ack_cyc[$], ack_port[$];
    bit cmd_w[$];
    logic [ADRS_W-1:0] cmd_a[$];
    logic [DATA_W-1:0] cmd_d[$], ack_dat[$];
    bit [2:0] rem;
    bit [2:0] acks;
    int n, budget, exp_lat, k;
    logic [DATA_W-1:0] exp_rd;

    rem = mask;
    n = $countones(mask);
    for (int i = 0; i < n; i++) begin
      k = pick_next(rem);
      exp_order.push_back(k);
      ptr_m = k;
      rem[k] = 1'b0;
    end
    exp_lat = mode_never ? 5 : 2 + mode_rise + mode_len;

    for (int p = 0; p < NPORT; p++) begin
      if (mask[p]) drive_port(p, 1'b1);
    end

    budget = 400;
    while (ack_port.size() < n && budget > 0) begin
      @(negedge m_clock);
      budget--;
      if (bus.psram_read || bus.psram_write) begin
        check_output({tag, "_one_cmd"}, 32'(bus.psram_read) + 32'(bus.psram_write), 32'd1);
        cmd_cyc.push_back(cycle);
        cmd_w.push_back(bus.psram_write);
        cmd_a.push_back(bus.psram_adrs);
        cmd_d.push_back(bus.psram_din);
      end
      acks = {bus.ack2, bus.ack1, bus.ack0};
      if (acks != 3'b000) begin
        check_output({tag, "_ack_onehot"}, $countones(acks), 32'd1);
        for (int p = 0; p < NPORT; p++) begin
          if (acks[p]) begin
            ack_port.push_back(p);
            ack_cyc.push_back(cycle);
            ack_dat.push_back(bus.rdata);
            drive_port(p, 1'b0);
          end
        end
      end
    end
    check_output({tag, "_timeout"}, 32'(budget > 0), 32'd1);
    check_output({tag, "_ncmd"}, cmd_cyc.size(), n);
    check_output({tag, "_nack"}, ack_port.size(), n);

    for (int i = 0; i < n && i < cmd_cyc.size() && i < ack_port.size(); i++) begin
      k = exp_order[i];
      check_output({tag, "_port"}, ack_port[i], k);
      check_output({tag, "_we"}, 32'(cmd_w[i]), 32'(p_we[k]));
      check_output({tag, "_adrs"}, 32'(cmd_a[i]), 32'(p_adrs[k]));
      if (p_we[k]) begin
        check_output({tag, "_din"}, 32'(cmd_d[i]), 32'(p_wdata[k]));
        ref_mem[p_adrs[k]] = p_wdata[k];
      end else begin
        exp_rd = ref_mem.exists(p_adrs[k]) ? ref_mem[p_adrs[k]] : dflt(p_adrs[k]);
        last_rd = exp_rd;
      end
      check_output({tag, "_rdata"}, 32'(ack_dat[i]), 32'(last_rd));
      check_output({tag, "_latency"}, ack_cyc[i] - cmd_cyc[i], exp_lat);
      if (i > 0) check_output({tag, "_spacing"}, 32'(cmd_cyc[i] - cmd_cyc[i-1] >= 5), 32'd1);
    end
  endtask

  task automatic random_port(input int p);
    p_we[p]    = 1'($urandom);
    p_adrs[p]  = 20'h00100 + 20'($urandom_range(0, 7));
    p_wdata[p] = 16'($urandom);
  endtask

  initial begin
    int pulses, budget;
    p_reset = 1'b1;
    busy_hold = 1'b1;
    bus.req0 = 0; bus.req1 = 0; bus.req2 = 0;
    bus.we0 = 0; bus.we1 = 0; bus.we2 = 0;
    bus.adrs0 = '0; bus.adrs1 = '0; bus.adrs2 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0; bus.wdata2 = '0;
    for (int p = 0; p < NPORT; p++) begin
      p_we[p] = 0; p_adrs[p] = '0; p_wdata[p] = '0;
    end
    repeat (3) @(negedge m_clock);

    check_output("rst_read",  32'(bus.psram_read), 32'd0);
    check_output("rst_write", 32'(bus.psram_write), 32'd0);
    check_output("rst_acks",  32'({bus.ack2, bus.ack1, bus.ack0}), 32'd0);
    check_output("rst_rdata", 32'(bus.rdata), 32'd0);
    check_output("rst_adrs",  32'(bus.psram_adrs), 32'd0);
    check_output("rst_din",   32'(bus.psram_din), 32'd0);

    // Busy held from reset: req0 must wait.
    p_we[0] = 1'b0; p_adrs[0] = 20'h0ABCD;
    drive_port(0, 1'b1);
    p_reset = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge m_clock);
      if (bus.psram_read || bus.psram_write) pulses++;
    end
    check_output("hold_no_cmd", pulses, 0);
    busy_hold = 1'b0;
    mode_never = 0; mode_rise = 0; mode_len = 2;
    apply_stimulus(3'b001, "hold");

    // Single read on port1.
    preload(20'h01234, 16'hBEEF);
    p_we[1] = 1'b0; p_adrs[1] = 20'h01234;
    mode_rise = 1; mode_len = 2;
    apply_stimulus(3'b010, "single");
    check_output("single_beef", 32'(bus.rdata), 32'h0000BEEF);

    // Simultaneous requests.
    p_we[0] = 1'b1; p_adrs[0] = 20'h00010; p_wdata[0] = 16'h55AA;
    p_we[1] = 1'b0; p_adrs[1] = 20'h00010;
    p_we[2] = 1'b0; p_adrs[2] = 20'h00777;
    mode_rise = 0; mode_len = 1;
    apply_stimulus(3'b111, "simul");

    // Busy never rises.
    mode_never = 1;
    p_we[2] = 1'b0; p_adrs[2] = 20'h00010;
    apply_stimulus(3'b100, "nobusy");

    // Reset during WAIT_DONE.
    mode_never = 0; mode_rise = 0; mode_len = 8;
    p_we[2] = 1'b0; p_adrs[2] = 20'h00321;
    drive_port(2, 1'b1);
    budget = 20;
    while (!bus.psram_read && budget > 0) begin
      @(negedge m_clock);
      budget--;
    end
    check_output("rstmid_cmd_seen", 32'(budget > 0), 32'd1);
    repeat (3) @(negedge m_clock);
    p_reset = 1'b1;
    #1;
    check_output("rstmid_read",  32'(bus.psram_read), 32'd0);
    check_output("rstmid_acks",  32'({bus.ack2, bus.ack1, bus.ack0}), 32'd0);
    check_output("rstmid_rdata", 32'(bus.rdata), 32'd0);
    check_output("rstmid_adrs",  32'(bus.psram_adrs), 32'd0);
    ptr_m = 0;
    last_rd = '0;
    pulses = 0;
    repeat (3) begin
      @(negedge m_clock);
      if (bus.ack0 || bus.ack1 || bus.ack2) pulses++;
    end
    check_output("rstmid_no_ack", pulses, 0);
    p_reset = 1'b0;
    mode_len = 2;
    apply_stimulus(3'b100, "rstmid");

    // Randomized batches.
    for (int it = 0; it < 12; it++) begin
      for (int p = 0; p < NPORT; p++) random_port(p);
      mode_never = ($urandom_range(0, 3) == 0);
      mode_rise  = $urandom_range(0, 2);
      mode_len   = $urandom_range(1, 4);
      apply_stimulus(3'($urandom_range(1, 7)), "rand");
    end

    repeat (3) @(negedge m_clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
